// File: rtl/sdram_slot_arbiter.sv
// sdram_slot_arbiter
// Shares one byte-wide SDRAM controller port between three requesters.
// Each clkref slot carries at most one access. Grants are round-robin, and
// an idle slot is forced after REFRESH_SLOTS consecutive accesses so the
// controller can issue AUTO_REFRESH (it refreshes when mem_oe = mem_we = 0).
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   clkref          slot reference shared with the controller
//   req/we/addr/din packed per-requester request, direction, address, data
//   ack             one-cycle pulse: request captured, inputs may change
//   done            one-cycle pulse: access complete (rdata valid for reads)
//   rdata           data of the last completed read
//   mem_*           controller port, registered and stable for a whole slot
module sdram_slot_arbiter #(
  parameter int unsigned ADDR_W        = 25,
  parameter int unsigned REFRESH_SLOTS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clkref,
  input  logic [2:0]            req,
  input  logic [2:0]            we,
  input  logic [3*ADDR_W-1:0]   addr,
  input  logic [23:0]           din,
  output logic [2:0]            ack,
  output logic [2:0]            done,
  output logic [7:0]            rdata,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic [7:0]            mem_din,
  input  logic [7:0]            mem_dout
);

  localparam logic [7:0] REFRESH_LIMIT = 8'(REFRESH_SLOTS);

  logic              clkref_q;
  logic              boundary;
  logic              owner_valid;
  logic [1:0]        owner;
  logic [1:0]        last_grant;
  logic [7:0]        busy_cnt;

  logic              grant_valid;
  logic [1:0]        grant_idx;
  logic [1:0]        cand;
  logic [ADDR_W-1:0] sel_addr;
  logic [7:0]        sel_din;
  logic              sel_we;

  assign boundary = clkref & ~clkref_q;

  // Round-robin scan: last_grant+1, +2, +3 (mod 3); first requester found wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = last_grant;
    for (int unsigned k = 0; k < 3; k++) begin
      cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_addr = addr[0 +: ADDR_W];
    sel_din  = din[7:0];
    sel_we   = we[0];
    case (grant_idx)
      2'd1: begin
        sel_addr = addr[ADDR_W +: ADDR_W];
        sel_din  = din[15:8];
        sel_we   = we[1];
      end
      2'd2: begin
        sel_addr = addr[2*ADDR_W +: ADDR_W];
        sel_din  = din[23:16];
        sel_we   = we[2];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clkref_q    <= 1'b0;
      ack         <= '0;
      done        <= '0;
      rdata       <= '0;
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      mem_oe      <= 1'b0;
      mem_din     <= '0;
      owner_valid <= 1'b0;
      owner       <= '0;
      last_grant  <= 2'd2;
      busy_cnt    <= '0;
    end else begin
      clkref_q <= clkref;
      ack      <= '0;
      done     <= '0;
      if (boundary) begin
        // Completion of the slot just ending; mem_oe still describes it.
        if (owner_valid) begin
          done <= 3'b001 << owner;
          if (mem_oe) rdata <= mem_dout;
        end
        if (busy_cnt == REFRESH_LIMIT || !grant_valid) begin
          // Idle slot: either forced for refresh or nothing requested.
          mem_oe      <= 1'b0;
          mem_we      <= 1'b0;
          owner_valid <= 1'b0;
          busy_cnt    <= '0;
        end else begin
          mem_addr    <= sel_addr;
          mem_din     <= sel_din;
          mem_we      <= sel_we;
          mem_oe      <= ~sel_we;
          ack         <= 3'b001 << grant_idx;
          owner       <= grant_idx;
          last_grant  <= grant_idx;
          owner_valid <= 1'b1;
          busy_cnt    <= busy_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// Directed bench for sdram_slot_arbiter. Slots are 4 clk cycles: clkref is
// high for two cycles, low for two. A second instance with REFRESH_SLOTS=4
// shares the stimulus and is checked only in the refresh scenario.
module tb_sdram_slot_arbiter;

  localparam int unsigned AW = 25;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clkref = 1'b0;
  logic [2:0]    req = '0;
  logic [2:0]    we = '0;
  logic [3*AW-1:0] addr = '0;
  logic [23:0]   din = '0;
  logic [7:0]    mem_dout = '0;

  logic [2:0]    ack, done;
  logic [7:0]    rdata, mem_din;
  logic [AW-1:0] mem_addr;
  logic          mem_we, mem_oe;

  logic [2:0]    ack_r, done_r;
  logic [7:0]    rdata_r, mem_din_r;
  logic [AW-1:0] mem_addr_r;
  logic          mem_we_r, mem_oe_r;

  int pass_cnt = 0;
  int total_cnt = 0;

  sdram_slot_arbiter #(.ADDR_W(AW), .REFRESH_SLOTS(16)) dut (
    .clk(clk), .reset(reset), .clkref(clkref), .req(req), .we(we),
    .addr(addr), .din(din), .ack(ack), .done(done), .rdata(rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_oe(mem_oe),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  sdram_slot_arbiter #(.ADDR_W(AW), .REFRESH_SLOTS(4)) dut_r (
    .clk(clk), .reset(reset), .clkref(clkref), .req(req), .we(we),
    .addr(addr), .din(din), .ack(ack_r), .done(done_r), .rdata(rdata_r),
    .mem_addr(mem_addr_r), .mem_we(mem_we_r), .mem_oe(mem_oe_r),
    .mem_din(mem_din_r), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Raise clkref; the next edge is the deciding edge of the boundary.
  task automatic boundary;
    clkref = 1'b1;
    tick();
  endtask

  task automatic rest_plain;
    tick();
    clkref = 1'b0;
    tick();
    tick();
  endtask

  // Remainder of a slot: no pulses, controller port held at expected values.
  task automatic rest_slot(input logic e_oe, input logic e_we, input logic [AW-1:0] e_addr);
    logic [AW+7:0] got, exp;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) clkref = 1'b0;
      tick();
      got = {ack, done, mem_oe, mem_we, mem_addr};
      exp = {6'b0, e_oe, e_we, e_addr};
      total_cnt++;
      if (got !== exp) $display("FAIL hold: got %h expected %h", got, exp);
      else pass_cnt++;
    end
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    addr[i*AW +: AW] = a;
  endtask

  task automatic test_reset;
    logic [AW+28:0] got;
    reset = 1'b1;
    clkref = 1'b0;
    tick(); tick(); tick();
    reset = 1'b0;
    tick();
    got = {ack, done, rdata, mem_addr, mem_we, mem_oe, mem_din};
    total_cnt++;
    if (got !== '0) $display("FAIL reset_outputs: got %h expected 0", got);
    else pass_cnt++;
  endtask

  task automatic test_single_read;
    req = 3'b010; we = 3'b000; set_addr(1, 25'h0001234);
    boundary();
    total_cnt++;
    if ({ack, done, mem_oe, mem_we, mem_addr} !== {3'b010, 3'b000, 1'b1, 1'b0, 25'h0001234})
      $display("FAIL read_grant: ack=%b done=%b oe=%b we=%b addr=%h expected 010 000 1 0 0001234",
               ack, done, mem_oe, mem_we, mem_addr);
    else pass_cnt++;
    req = 3'b000;
    rest_slot(1'b1, 1'b0, 25'h0001234);
    mem_dout = 8'h5A;
    boundary();
    total_cnt++;
    if ({ack, done, rdata, mem_oe} !== {3'b000, 3'b010, 8'h5A, 1'b0})
      $display("FAIL read_done: ack=%b done=%b rdata=%h oe=%b expected 000 010 5a 0",
               ack, done, rdata, mem_oe);
    else pass_cnt++;
    rest_slot(1'b0, 1'b0, 25'h0001234);
  endtask

  task automatic test_write;
    req = 3'b001; we = 3'b001; din[7:0] = 8'hC3; set_addr(0, 25'h0ABCDEF);
    boundary();
    total_cnt++;
    if ({ack, mem_we, mem_oe, mem_din, mem_addr} !== {3'b001, 1'b1, 1'b0, 8'hC3, 25'h0ABCDEF})
      $display("FAIL write_grant: ack=%b we=%b oe=%b din=%h addr=%h expected 001 1 0 c3 0abcdef",
               ack, mem_we, mem_oe, mem_din, mem_addr);
    else pass_cnt++;
    req = 3'b000; we = 3'b000;
    rest_slot(1'b0, 1'b1, 25'h0ABCDEF);
    mem_dout = 8'h77;
    boundary();
    total_cnt++;
    if ({done, rdata, mem_we} !== {3'b001, 8'h5A, 1'b0})
      $display("FAIL write_done: done=%b rdata=%h we=%b expected 001 5a 0", done, rdata, mem_we);
    else pass_cnt++;
    rest_slot(1'b0, 1'b0, 25'h0ABCDEF);
  endtask

  task automatic test_late_request;
    set_addr(2, 25'h1FFFFFF);
    boundary();
    total_cnt++;
    if (ack !== 3'b000) $display("FAIL late_idle_ack: got %b expected 000", ack);
    else pass_cnt++;
    req = 3'b100;
    rest_slot(1'b0, 1'b0, 25'h0ABCDEF);
    boundary();
    total_cnt++;
    if ({ack, mem_oe, mem_addr} !== {3'b100, 1'b1, 25'h1FFFFFF})
      $display("FAIL late_grant: ack=%b oe=%b addr=%h expected 100 1 1ffffff", ack, mem_oe, mem_addr);
    else pass_cnt++;
    req = 3'b000;
    rest_slot(1'b1, 1'b0, 25'h1FFFFFF);
    mem_dout = 8'h3C;
    boundary();
    total_cnt++;
    if ({ack, done, rdata} !== {3'b000, 3'b100, 8'h3C})
      $display("FAIL late_done: ack=%b done=%b rdata=%h expected 000 100 3c", ack, done, rdata);
    else pass_cnt++;
    rest_slot(1'b0, 1'b0, 25'h1FFFFFF);
  endtask

  task automatic test_contention;
    logic [AW-1:0] a [3];
    logic [2:0] e_ack, e_done;
    a[0] = 25'h0000111; a[1] = 25'h0000222; a[2] = 25'h0000333;
    for (int i = 0; i < 3; i++) set_addr(i, a[i]);
    req = 3'b111; we = 3'b000;
    for (int k = 0; k < 6; k++) begin
      mem_dout = 8'h10 + 8'(k);
      boundary();
      e_ack  = 3'(1 << (k % 3));
      e_done = (k == 0) ? 3'b000 : 3'(1 << ((k - 1) % 3));
      total_cnt++;
      if ({ack, done, mem_addr} !== {e_ack, e_done, a[k % 3]})
        $display("FAIL contention_slot%0d: ack=%b done=%b addr=%h expected %b %b %h",
                 k, ack, done, mem_addr, e_ack, e_done, a[k % 3]);
      else pass_cnt++;
      if (k > 0) begin
        total_cnt++;
        if (rdata !== 8'h10 + 8'(k))
          $display("FAIL contention_rdata%0d: got %h expected %h", k, rdata, 8'h10 + 8'(k));
        else pass_cnt++;
      end
      rest_plain();
    end
    req = 3'b000;
    mem_dout = 8'h16;
    boundary();
    total_cnt++;
    if ({ack, done, rdata, mem_oe} !== {3'b000, 3'b100, 8'h16, 1'b0})
      $display("FAIL contention_drain: ack=%b done=%b rdata=%h oe=%b expected 000 100 16 0",
               ack, done, rdata, mem_oe);
    else pass_cnt++;
    rest_plain();
  endtask

  task automatic test_refresh;
    logic [2:0] e_ack  [6];
    logic [2:0] e_done [6];
    logic       e_oe   [6];
    e_ack  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b000, 3'b010};
    e_done = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b001, 3'b000};
    e_oe   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    reset = 1'b1; clkref = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    req = 3'b111; we = 3'b000;
    for (int k = 0; k < 6; k++) begin
      boundary();
      total_cnt++;
      if ({ack_r, done_r, mem_oe_r, mem_we_r} !== {e_ack[k], e_done[k], e_oe[k], 1'b0})
        $display("FAIL refresh_slot%0d: ack=%b done=%b oe=%b we=%b expected %b %b %b 0",
                 k, ack_r, done_r, mem_oe_r, mem_we_r, e_ack[k], e_done[k], e_oe[k]);
      else pass_cnt++;
      rest_plain();
    end
    req = 3'b000;
  endtask

  task automatic test_reset_mid_slot;
    logic [AW+28:0] got;
    reset = 1'b1; clkref = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    set_addr(0, 25'h0000ABC);
    set_addr(1, 25'h0001234);
    req = 3'b010; we = 3'b000;
    boundary();
    total_cnt++;
    if ({ack, mem_oe} !== {3'b010, 1'b1})
      $display("FAIL midreset_grant: ack=%b oe=%b expected 010 1", ack, mem_oe);
    else pass_cnt++;
    tick();
    reset = 1'b1; clkref = 1'b0;
    tick();
    reset = 1'b0;
    got = {ack, done, rdata, mem_addr, mem_we, mem_oe, mem_din};
    total_cnt++;
    if (got !== '0) $display("FAIL midreset_outputs: got %h expected 0", got);
    else pass_cnt++;
    req = 3'b111;
    tick(); tick();
    boundary();
    total_cnt++;
    if ({ack, done, mem_oe, mem_addr} !== {3'b001, 3'b000, 1'b1, 25'h0000ABC})
      $display("FAIL midreset_regrant: ack=%b done=%b oe=%b addr=%h expected 001 000 1 0000abc",
               ack, done, mem_oe, mem_addr);
    else pass_cnt++;
    req = 3'b000;
    rest_plain();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_late_request();
    test_contention();
    test_refresh();
    test_reset_mid_slot();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
